// File: rtl/board_uart_tx.sv
// Purpose : serialises a 4x4 board snapshot (16 x 20-bit tiles) plus the 21-bit score into one 8N1 UART frame.
// Latency : the start bit of the sync byte drives tx the cycle after start is accepted; the frame lasts N_BYTES*10*CLKS_PER_BIT cycles.
// Backpr. : none; start is honoured only while busy=0, is ignored while busy=1 and is never queued.
//
// Ports: clk/rst (synchronous, active-high reset), start (frame request),
//        board[319:0] (tile i at [20*i+19:20*i]), score[20:0],
//        busy (frame in flight), done (one-cycle pulse on completion), tx (serial line, idle high).
// Optional: define BOARD_TX_CHECKSUM_EN to append an XOR checksum of the 51 payload bytes (53-byte frame instead of 52).
module board_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [319:0] board,
    input  logic [20:0]  score,
    output logic         busy,
    output logic         done,
    output logic         tx
);

`ifdef BOARD_TX_CHECKSUM_EN
    localparam int N_BYTES = 53;
`else
    localparam int N_BYTES = 52;
`endif
    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [5:0]        BYTE_LAST = 6'(N_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [2:0]          bit_idx;
    logic [5:0]          byte_idx;
    logic [7:0]          shift_q;
    logic [319:0]        snap_board;
    logic [20:0]         snap_score;
    logic                done_q;
`ifdef BOARD_TX_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic [7:0]          frame [0:N_BYTES-1];
    logic                baud_last;
    logic                last_byte;
    logic                frame_end;
    logic [5:0]          next_idx;
    logic [7:0]          next_byte;

    // Byte mux over the snapshot: every field is zero-extended to 24 bits and sent MSB byte first.
    always_comb begin
        frame[0] = SYNC_BYTE;
        for (int t = 0; t < 16; t++) begin
            frame[1 + 3*t] = {4'h0, snap_board[20*t + 16 +: 4]};
            frame[2 + 3*t] = snap_board[20*t + 8 +: 8];
            frame[3 + 3*t] = snap_board[20*t +: 8];
        end
        frame[49] = {3'b000, snap_score[20:16]};
        frame[50] = snap_score[15:8];
        frame[51] = snap_score[7:0];
`ifdef BOARD_TX_CHECKSUM_EN
        frame[52] = csum_q;
`endif
    end

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign last_byte = (byte_idx == BYTE_LAST);
    assign frame_end = (state_q == STOP) && baud_last && last_byte;
    // Clamped so the mux index never leaves the frame, even on the final stop bit.
    assign next_idx  = last_byte ? byte_idx : byte_idx + 6'd1;
    assign next_byte = frame[next_idx];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and line level
    always_comb begin
        state_d = state_q;
        tx      = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud_last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (baud_last && (bit_idx == 3'd7)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_d = last_byte ? IDLE : START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: snapshot, counters, shift register, checksum, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shift_q    <= '0;
            snap_board <= '0;
            snap_score <= '0;
            done_q     <= 1'b0;
`ifdef BOARD_TX_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            done_q <= frame_end;

            // Held at 0 while idle so the first start bit gets a full period.
            if ((state_q == IDLE) || baud_last) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_board <= board;
                        snap_score <= score;
                        byte_idx   <= '0;
                        bit_idx    <= '0;
                        shift_q    <= SYNC_BYTE;
`ifdef BOARD_TX_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (baud_last && !last_byte) begin
                        byte_idx <= next_idx;
                        shift_q  <= next_byte;
`ifdef BOARD_TX_CHECKSUM_EN
                        // Fold in payload bytes only; the checksum slot itself is excluded.
                        if (next_idx != BYTE_LAST) begin
                            csum_q <= csum_q ^ next_byte;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: doc/board_uart_tx.md
Name: board_uart_tx

Overview:
Serializes a snapshot of the 4x4 game board (16 tiles x 20 bits) and the 21-bit score into one fixed-length UART frame on a single tx pin: 8N1, idle-high. It is the outbound counterpart of the button/direction input path. The game controller's board/score outputs drive it, and a host or terminal receives the frame. Frame layout: sync byte, tile data, score, then an optional checksum.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 2
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request to send one frame; sampled every clk
board  input  320  tile i = board[20*i+19 : 20*i], i = 0..15
score  input  21  current score
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when a frame completes
tx  output  1  UART serial line, idle high

Behaviour:
- Reset state: tx=1, busy=0, done=0, FSM in IDLE, all counters 0. Reset applies at the next clk edge.
- Reset mid-frame: the frame is abandoned. tx=1 in the cycle after reset is sampled. No done pulse is generated.
- Acceptance: start is accepted only when busy=0. Start while busy=1 is ignored; it is not queued.
- On acceptance at edge k:
  - board and score are latched into an internal snapshot.
  - Later input changes do not affect the frame in flight.
  - busy=1 from cycle k+1.
- Byte sequence:
  - SYNC_BYTE first.
  - Then tiles 0..15. Each tile is zero-extended to 24 bits and sent as 3 bytes, MSB byte first.
  - Then score, zero-extended to 24 bits, as 3 bytes, MSB byte first.
  - Then the checksum byte (see Optional Feature).
  - Frame length N_BYTES = 53 with checksum, 52 without.
- Per byte:
  - Start bit (tx=0), then 8 data bits LSB first, then stop bit (tx=1).
  - Each bit holds for exactly CLKS_PER_BIT cycles.
  - Bytes are back-to-back, with no idle gap between a stop bit and the next start bit.
- FSM states:
  - IDLE -> START on accepted start.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if bytes remain; STOP -> IDLE after the last byte.
- Timing:
  - The start bit of the first byte occupies cycles k+1 .. k+CLKS_PER_BIT.
  - busy stays high for exactly N_BYTES*10*CLKS_PER_BIT cycles.
  - In the next cycle, busy=0 and done=1 for one cycle.
- Back-to-back: start asserted in the cycle where done=1 is accepted (busy=0 there). The next frame's start bit begins in the following cycle, so there is zero idle time.
- Counters:
  - Baud counter: 0..CLKS_PER_BIT-1.
  - Bit index: 0..7.
  - Byte index: 0..N_BYTES-1.
  - None of the counters wraps beyond its terminal value.
- Byte mux: selected combinationally from the snapshot by byte index. The current byte is registered into a shift register at each START entry.

Optional Feature:
Macro BOARD_TX_CHECKSUM_EN.
- Defined: a 53rd byte is appended. It is the XOR of all 51 payload bytes (tile and score bytes; SYNC_BYTE excluded), accumulated as each payload byte is loaded.
- Undefined: the frame ends after the last score byte (N_BYTES=52). No checksum logic is present.

Test Plan:
(Run with CLKS_PER_BIT=4, checksum enabled unless stated.)
1. Zero board and score=0; pulse start -> decoded bytes A5, 51 x 00, 00. busy high for exactly 2120 cycles, then a single done pulse. tx=1 afterwards.
2. Tile0=20'h00002, tile15=20'h80000, score=21'h01ABCD, other tiles 0:
   - Decoded bytes 2-4 are 00 00 02.
   - Bytes 47-49 are 08 00 00.
   - Bytes 50-52 are 01 AB CD.
   - Checksum is 6D.
3. Change board and pulse start repeatedly while busy -> frame content matches the first snapshot, no second frame follows, and done pulses exactly once.
4. Assert start in the done cycle -> the second frame's start bit (tx=0) begins the next cycle. Two complete frames are decoded with no idle bits between them.
5. Assert rst at byte 10 mid-bit -> tx=1, busy=0 the next cycle, no done pulse. A subsequent start produces a full, correct frame.
6. BOARD_TX_CHECKSUM_EN undefined, stimulus as in scenario 2 -> 52 bytes ending in CD. busy lasts 2080 cycles.
